// File: rtl/peripheral_dbg_pu_riscv_jtag_pkg.sv
// Shared types and constants for the RISC-V debug JTAG TAP.
// TAP states, opcode values, IR capture pattern and the instruction-to-DR decode.
package peripheral_dbg_pu_riscv_jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USERCODE,
        DR_DEBUG
    } dr_sel_t;

    localparam int IR_WIDTH_DEFAULT = 4;

    localparam logic [3:0] OPC_EXTEST         = 4'b0000;
    localparam logic [3:0] OPC_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] OPC_IDCODE         = 4'b0010;
    localparam logic [3:0] OPC_USERCODE       = 4'b0011;
    localparam logic [3:0] OPC_DEBUG          = 4'b1000;
    localparam logic [3:0] OPC_BYPASS         = 4'b1111;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    // No boundary chain exists, so EXTEST/SAMPLE_PRELOAD and anything unknown fall to BYPASS.
    function automatic dr_sel_t decode_ir(input logic [3:0] op, input logic usercode_en);
        case (op)
            OPC_IDCODE:   return DR_IDCODE;
            OPC_DEBUG:    return DR_DEBUG;
            OPC_USERCODE: return usercode_en ? DR_USERCODE : DR_BYPASS;
            OPC_EXTEST, OPC_SAMPLE_PRELOAD, OPC_BYPASS: return DR_BYPASS;
            default:      return DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_jtag_fsm.sv
// IEEE 1149.1 TAP state machine: TMS decode into the 16 TAP states.
// Synchronous active-high reset on tck_i forces TEST_LOGIC_RESET.
module peripheral_dbg_pu_riscv_jtag_fsm
    import peripheral_dbg_pu_riscv_jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_q;

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            case (state_q)
                TEST_LOGIC_RESET: state_q <= tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_q <= tms_i ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_DR:        state_q <= tms_i ? SELECT_IR        : CAPTURE_DR;
                CAPTURE_DR:       state_q <= tms_i ? EXIT1_DR         : SHIFT_DR;
                SHIFT_DR:         state_q <= tms_i ? EXIT1_DR         : SHIFT_DR;
                EXIT1_DR:         state_q <= tms_i ? UPDATE_DR        : PAUSE_DR;
                PAUSE_DR:         state_q <= tms_i ? EXIT2_DR         : PAUSE_DR;
                EXIT2_DR:         state_q <= tms_i ? UPDATE_DR        : SHIFT_DR;
                UPDATE_DR:        state_q <= tms_i ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_IR:        state_q <= tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_q <= tms_i ? EXIT1_IR         : SHIFT_IR;
                SHIFT_IR:         state_q <= tms_i ? EXIT1_IR         : SHIFT_IR;
                EXIT1_IR:         state_q <= tms_i ? UPDATE_IR        : PAUSE_IR;
                PAUSE_IR:         state_q <= tms_i ? EXIT2_IR         : PAUSE_IR;
                EXIT2_IR:         state_q <= tms_i ? UPDATE_IR        : SHIFT_IR;
                UPDATE_IR:        state_q <= tms_i ? SELECT_DR        : RUN_TEST_IDLE;
                default:          state_q <= TEST_LOGIC_RESET;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/peripheral_dbg_pu_riscv_jtag_tap.sv
// JTAG TAP in front of the RISC-V debug top: IR, IDCODE/BYPASS registers and TDO mux.
// Optional USERCODE instruction enabled by defining PERIPHERAL_DBG_TAP_USERCODE_EN.
module peripheral_dbg_pu_riscv_jtag_tap
    import peripheral_dbg_pu_riscv_jtag_pkg::*;
#(
    parameter int          IR_WIDTH       = IR_WIDTH_DEFAULT,
    parameter logic [31:0] IDCODE_VALUE   = 32'h149511C3,
    parameter logic [31:0] USERCODE_VALUE = 32'h00000000
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic tlr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o
);

`ifdef PERIPHERAL_DBG_TAP_USERCODE_EN
    localparam logic USERCODE_EN = 1'b1;
`else
    localparam logic USERCODE_EN = 1'b0;
`endif

    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
    localparam int                  IR_EXT_W   = IR_WIDTH + 4;

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [31:0]         id_sr_q;
    logic                bypass_q;
    logic                tdo_q;
    logic                tdo_oe_q;
    logic [IR_EXT_W-1:0] ir_ext;
    dr_sel_t             dr_sel;
    logic                tlr_entry;
    logic                sel_id_sr;

    peripheral_dbg_pu_riscv_jtag_fsm u_fsm (
        .tck_i   (tck_i),
        .rst_i   (rst_i),
        .tms_i   (tms_i),
        .state_o (state)
    );

    // Opcodes wider than four bits only match when the extra IR bits are zero.
    assign ir_ext    = IR_EXT_W'(ir_q);
    assign dr_sel    = (ir_ext[IR_EXT_W-1:4] == '0) ? decode_ir(ir_ext[3:0], USERCODE_EN)
                                                    : DR_BYPASS;
    assign sel_id_sr = (dr_sel == DR_IDCODE) || (dr_sel == DR_USERCODE);

    // Only SELECT_IR with TMS high enters TLR, so IDCODE is in place on the same edge.
    assign tlr_entry = (state == TEST_LOGIC_RESET) || ((state == SELECT_IR) && tms_i);

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            ir_q     <= IR_RESET;
            ir_sr_q  <= '0;
            id_sr_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (tlr_entry) begin
                ir_q <= IR_RESET;
            end else if (state == UPDATE_IR) begin
                ir_q <= ir_sr_q;
            end

            case (state)
                CAPTURE_IR: ir_sr_q <= IR_CAP_VAL;
                SHIFT_IR:   ir_sr_q <= {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
                default:    ;
            endcase

            // IDCODE and USERCODE share one 32-bit shifter; USERCODE is never selected when disabled.
            if (state == CAPTURE_DR) begin
                if (dr_sel == DR_BYPASS) begin
                    bypass_q <= 1'b0;
                end
                if (dr_sel == DR_USERCODE) begin
                    id_sr_q <= USERCODE_VALUE;
                end else if (dr_sel == DR_IDCODE) begin
                    id_sr_q <= IDCODE_VALUE;
                end
            end else if (state == SHIFT_DR) begin
                if (dr_sel == DR_BYPASS) begin
                    bypass_q <= tdi_i;
                end
                if (sel_id_sr) begin
                    id_sr_q <= {tdi_i, id_sr_q[31:1]};
                end
            end
        end
    end

    always_ff @(negedge tck_i) begin
        if (state == TEST_LOGIC_RESET) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_oe_q <= (state == SHIFT_IR) || (state == SHIFT_DR);
            case (state)
                SHIFT_IR: tdo_q <= ir_sr_q[0];
                SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE, DR_USERCODE: tdo_q <= id_sr_q[0];
                        DR_DEBUG:               tdo_q <= debug_tdo_i;
                        default:                tdo_q <= bypass_q;
                    endcase
                end
                default:  tdo_q <= 1'b0;
            endcase
        end
    end

    assign tdo_o          = tdo_q;
    assign tdo_oe_o       = tdo_oe_q;
    assign tlr_o          = (state == TEST_LOGIC_RESET);
    assign shift_dr_o     = (state == SHIFT_DR);
    assign pause_dr_o     = (state == PAUSE_DR);
    assign update_dr_o    = (state == UPDATE_DR);
    assign capture_dr_o   = (state == CAPTURE_DR);
    assign debug_select_o = (dr_sel == DR_DEBUG);

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_jtag_tap.sv
// Bench for the JTAG TAP: directed scans plus a random TMS/TDI walk against a queue-based model.
// Define PERIPHERAL_DBG_TAP_USERCODE_EN to expect the USERCODE instruction.
module tb_peripheral_dbg_pu_riscv_jtag_tap;

    localparam logic [31:0] IDV = 32'h149511C3;
    localparam logic [31:0] UCV = 32'hDEADBEEF;

    localparam int TLR = 0,  RTI = 1,  SDR = 2,  CDR = 3,  SHDR = 4,  E1DR = 5,  PDR = 6,  E2DR = 7;
    localparam int UDR = 8,  SIR = 9,  CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    int nxt0 [16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
    int nxt1 [16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

    logic tck_i = 1'b0;
    logic rst_i = 1'b1;
    logic tms_i = 1'b1;
    logic tdi_i = 1'b0;
    logic debug_tdo_i = 1'b0;
    logic tdo_o, tdo_oe_o, tlr_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o, debug_select_o;

    always #5 tck_i = ~tck_i;

    peripheral_dbg_pu_riscv_jtag_tap #(
        .IR_WIDTH       (4),
        .IDCODE_VALUE   (IDV),
        .USERCODE_VALUE (UCV)
    ) dut (
        .tck_i          (tck_i),
        .rst_i          (rst_i),
        .tms_i          (tms_i),
        .tdi_i          (tdi_i),
        .tdo_o          (tdo_o),
        .tdo_oe_o       (tdo_oe_o),
        .debug_tdo_i    (debug_tdo_i),
        .tlr_o          (tlr_o),
        .shift_dr_o     (shift_dr_o),
        .pause_dr_o     (pause_dr_o),
        .update_dr_o    (update_dr_o),
        .capture_dr_o   (capture_dr_o),
        .debug_select_o (debug_select_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: state by table lookup, shift registers as bit queues (front = bit shifted out).
    int         m_state = TLR;
    logic [3:0] m_ir    = 4'b0010;
    bit         irq[$];
    bit         drq[$];

    // 0 bypass, 1 idcode, 2 debug, 3 usercode
    function automatic int kind(input logic [3:0] ir);
        if (ir == 4'b0010) return 1;
        if (ir == 4'b1000) return 2;
`ifdef PERIPHERAL_DBG_TAP_USERCODE_EN
        if (ir == 4'b0011) return 3;
`endif
        return 0;
    endfunction

    task automatic load_dr(input logic [31:0] v);
        drq.delete();
        for (int i = 0; i < 32; i++) drq.push_back(v[i]);
    endtask

    task automatic step(input bit r, input bit t, input bit d, input bit dt);
        int ns;
        bit exp_tdo;
        rst_i = r; tms_i = t; tdi_i = d; debug_tdo_i = dt;
        @(posedge tck_i); #1;
        ns = r ? TLR : (t ? nxt1[m_state] : nxt0[m_state]);
        if (r) begin
            irq.delete();
            drq.delete();
        end else begin
            case (m_state)
                CIR:  irq = {1'b1, 1'b0, 1'b0, 1'b0};
                SHIR: if (irq.size() > 0) begin irq.push_back(d); void'(irq.pop_front()); end
                UIR:  if (irq.size() == 4) m_ir = {irq[3], irq[2], irq[1], irq[0]};
                CDR: begin
                    case (kind(m_ir))
                        1:       load_dr(IDV);
                        3:       load_dr(UCV);
                        2:       drq.delete();
                        default: drq = {1'b0};
                    endcase
                end
                SHDR: if (drq.size() > 0) begin drq.push_back(d); void'(drq.pop_front()); end
                default: ;
            endcase
        end
        if (ns == TLR) m_ir = 4'b0010;
        m_state = ns;
        chk("tlr_o",          tlr_o,          m_state == TLR);
        chk("shift_dr_o",     shift_dr_o,     m_state == SHDR);
        chk("pause_dr_o",     pause_dr_o,     m_state == PDR);
        chk("update_dr_o",    update_dr_o,    m_state == UDR);
        chk("capture_dr_o",   capture_dr_o,   m_state == CDR);
        chk("debug_select_o", debug_select_o, kind(m_ir) == 2);
        @(negedge tck_i); #1;
        exp_tdo = 1'b0;
        if (m_state == SHIR && irq.size() > 0) exp_tdo = irq[0];
        if (m_state == SHDR) exp_tdo = (kind(m_ir) == 2) ? dt : ((drq.size() > 0) ? drq[0] : 1'b0);
        chk("tdo_oe_o", tdo_oe_o, (m_state == SHIR) || (m_state == SHDR));
        chk("tdo_o",    tdo_o,    exp_tdo);
    endtask

    // Both scans start and end in RUN_TEST_IDLE.
    task automatic scan_ir(input logic [3:0] v, output logic [3:0] out);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            out[i] = tdo_o;
            step(0, i == 3, v[i], 0);
        end
        step(0, 1, 0, 0); step(0, 0, 0, 0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din, input logic [64:0] dts,
                           output logic [63:0] out);
        out = '0;
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, dts[0]);
        for (int i = 0; i < n; i++) begin
            out[i] = tdo_o;
            step(0, i == n - 1, din[i], dts[i+1]);
        end
        step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    endtask

    logic [3:0]  o4;
    logic [63:0] o;

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_tlr",  tlr_o,          1'b1);
        chk("reset_dsel", debug_select_o, 1'b0);
        chk("reset_oe",   tdo_oe_o,       1'b0);
        chk("reset_tdo",  tdo_o,          1'b0);
        step(0, 0, 0, 0);

        scan_dr(32, 64'h0, 65'h0, o);
        chk("idcode_read", o[31:0], 32'h149511C3);

        scan_ir(4'b1000, o4);
        chk("ir_capture", o4, 4'b0001);
        chk("dsel_debug", debug_select_o, 1'b1);
        scan_dr(3, 64'h0, 65'b0101, o);
        chk("debug_tdo_passthru", o[2:0], 3'b101);
        chk("dsel_stable", debug_select_o, 1'b1);

        scan_ir(4'b1111, o4);
        scan_dr(9, 64'hA5, 65'h0, o);
        chk("bypass_1111", o[8:0], 9'h14A);
        scan_ir(4'b0110, o4);
        scan_dr(9, 64'hA5, 65'h0, o);
        chk("bypass_unknown", o[8:0], 9'h14A);

        scan_ir(4'b0011, o4);
        scan_dr(32, 64'h0, 65'h0, o);
`ifdef PERIPHERAL_DBG_TAP_USERCODE_EN
        chk("usercode_read", o[31:0], 32'hDEADBEEF);
`else
        chk("usercode_off_bypass", o[31:0], 32'h0);
`endif

        // TMS reset from SHIFT_DR: four ones stop at SELECT_IR, the fifth reaches TLR.
        scan_ir(4'b1000, o4);
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("tms4_not_tlr", tlr_o, 1'b0);
        chk("tms4_dsel",    debug_select_o, 1'b1);
        step(0, 1, 0, 0);
        chk("tms5_tlr",  tlr_o, 1'b1);
        chk("tms5_dsel", debug_select_o, 1'b0);
        step(0, 0, 0, 0);

        // Reset in the middle of an IR scan must not update the IR.
        scan_ir(4'b1000, o4);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("midscan_rst_dsel", debug_select_o, 1'b0);
        step(0, 0, 0, 0);
        scan_dr(32, 64'h0, 65'h0, o);
        chk("midscan_idcode", o[31:0], 32'h149511C3);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 35,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
